// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV sequencer for RV64.
// Runs a radix-2 shift-add multiplier or a restoring divider, one bit per cycle,
// then applies sign correction and W-op sign-extension in a single fix-up cycle.
module mdu_sequencer #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [2:0] OpMul  = 3'd0;
  localparam logic [2:0] OpMulw = 3'd1;
  localparam logic [2:0] OpDiv  = 3'd2;
  localparam logic [2:0] OpDivu = 3'd3;
  localparam logic [2:0] OpRem  = 3'd4;
  localparam logic [2:0] OpRemu = 3'd5;
  localparam logic [2:0] OpDivw = 3'd6;
  localparam logic [2:0] OpRemw = 3'd7;

  // Most-negative dividend, already in the sign-extended form used internally.
  localparam logic [XLEN-1:0] MinNeg64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MinNegW  = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // x: multiplicand / dividend-quotient shifter; y: multiplier / divisor magnitude
  logic [XLEN-1:0]   x_q, x_d;
  logic [XLEN-1:0]   y_q, y_d;
  // acc: product accumulator / partial remainder
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              w_q, w_d;
  logic              div_q, div_d;
  logic              is_rem_q, is_rem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic              in_w, in_div, in_signed, in_rem;
  logic [XLEN-1:0]   s1_ext, s2_ext, mag1, mag2, min_neg, special_res;
  logic              neg1, neg2, div0, ovf;
  logic [XLEN:0]     shifted, diff;
  logic              ge;
  logic [XLEN-1:0]   mul_sum, quo, rmd, sel, fix_res;

  // Decode the incoming op into class flags.
  always_comb begin
    in_w      = 1'b0;
    in_div    = 1'b0;
    in_signed = 1'b0;
    in_rem    = 1'b0;
    case (op)
      OpMul:  ;
      OpMulw: in_w = 1'b1;
      OpDiv:  begin in_div = 1'b1; in_signed = 1'b1; end
      OpDivu: in_div = 1'b1;
      OpRem:  begin in_div = 1'b1; in_signed = 1'b1; in_rem = 1'b1; end
      OpRemu: begin in_div = 1'b1; in_rem = 1'b1; end
      OpDivw: begin in_w = 1'b1; in_div = 1'b1; in_signed = 1'b1; end
      OpRemw: begin in_w = 1'b1; in_div = 1'b1; in_signed = 1'b1; in_rem = 1'b1; end
      default: ;
    endcase
  end

  // Operand conditioning: W ops work on sign-extended low halves, divides on magnitudes.
  always_comb begin
    s1_ext  = in_w ? {{(XLEN-32){src1[31]}}, src1[31:0]} : src1;
    s2_ext  = in_w ? {{(XLEN-32){src2[31]}}, src2[31:0]} : src2;
    neg1    = in_signed & s1_ext[XLEN-1];
    neg2    = in_signed & s2_ext[XLEN-1];
    mag1    = neg1 ? -s1_ext : s1_ext;
    mag2    = neg2 ? -s2_ext : s2_ext;
    min_neg = in_w ? MinNegW : MinNeg64;
    div0    = in_div & (s2_ext == '0);
    ovf     = in_signed & (s1_ext == min_neg) & (&s2_ext);
    if (div0) begin
      special_res = in_rem ? s1_ext : '1;
    end else begin
      special_res = in_rem ? '0 : s1_ext;
    end
  end

  // One iteration of each algorithm plus the final sign fix-up.
  always_comb begin
    mul_sum = acc_q + (y_q[0] ? x_q : '0);
    shifted = {acc_q, x_q[XLEN-1]};
    diff    = shifted - {1'b0, y_q};
    ge      = ~diff[XLEN];
    quo     = qneg_q ? -x_q : x_q;
    rmd     = rneg_q ? -acc_q : acc_q;
    if (!div_q) begin
      sel = acc_q;
    end else begin
      sel = is_rem_q ? rmd : quo;
    end
    fix_res = w_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    res_d    = res_q;
    w_d      = w_q;
    div_d    = div_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            w_d      = in_w;
            div_d    = in_div;
            is_rem_d = in_rem;
            qneg_d   = neg1 ^ neg2;
            rneg_d   = neg1;
            acc_d    = '0;
            cnt_d    = in_w ? CntW'(31) : CntW'(XLEN - 1);
            if (div0 || ovf) begin
              res_d   = special_res;
              state_d = StDone;
            end else begin
              if (in_div) begin
                // W dividends are left-aligned so the MSB feed is always bit XLEN-1.
                x_d = in_w ? {mag1[31:0], {(XLEN-32){1'b0}}} : mag1;
                y_d = mag2;
              end else begin
                x_d = src1;
                y_d = src2;
              end
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          if (div_q) begin
            acc_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            x_d   = {x_q[XLEN-2:0], ge};
          end else begin
            acc_d = mul_sum;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
          end
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_d = StFix;
          end
        end
        StFix: begin
          res_d   = fix_res;
          state_d = StDone;
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and latched-op registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      w_q      <= 1'b0;
      div_q    <= 1'b0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      w_q      <= w_d;
      div_q    <= div_d;
      is_rem_q <= is_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;

endmodule
